// File: rtl/mux_rr_pkg.sv
// Shared definitions for the two-channel round-robin feeder: default sizes,
// arbiter state encoding and channel source codes.
package mux_rr_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 2;

    localparam logic SRC_IN1 = 1'b0;
    localparam logic SRC_IN2 = 1'b1;

    // bit 1 = output word valid, bit 0 = source channel of the held word
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HOLD1 = 2'b10,
        HOLD2 = 2'b11
    } state_t;

    function automatic state_t hold_state(input logic src);
        return (src == SRC_IN2) ? HOLD2 : HOLD1;
    endfunction

endpackage

// File: rtl/mux_rr_feeder_if.sv
// Handshake bundle for the feeder: two input channels and one output channel.
interface mux_rr_feeder_if #(
    parameter int WIDTH = mux_rr_pkg::WIDTH_DEF
);
    logic [WIDTH-1:0] in1;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] in2;
    logic             in2_valid;
    logic             in2_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             out_sel;

    modport master (
        output in1, in1_valid, input in1_ready,
        output in2, in2_valid, input in2_ready,
        input  out, out_valid, out_sel,
        output out_ready
    );

    modport slave (
        input  in1, in1_valid, output in1_ready,
        input  in2, in2_valid, output in2_ready,
        output out, out_valid, out_sel,
        input  out_ready
    );
endinterface

// File: rtl/mux_rr_fifo.sv
// Small synchronous FIFO feeding one arbiter input; DEPTH must be 2 or 4 so
// the pointers wrap naturally.
module mux_rr_fifo
    import mux_rr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; stale words are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mux_rr_feeder.sv
// Two buffered input channels merged into one registered output with
// round-robin arbitration on ties.
module mux_rr_feeder
    import mux_rr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    mux_rr_feeder_if.slave bus
);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] head1, head2, head_sel;
    logic [CW-1:0]    count1, count2;
    logic             full1, full2, empty1, empty2;
    logic             push1, push2, pop1, pop2;
    logic             loadable, load, pick;

    state_t           state;
    logic [WIDTH-1:0] out_q;
    logic             sel_q;
    logic             last;

    assign push1 = bus.in1_valid && !full1 && !rst;
    assign push2 = bus.in2_valid && !full2 && !rst;

    mux_rr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .push(push1), .pop(pop1), .din(bus.in1),
        .head(head1), .count(count1), .full(full1), .empty(empty1)
    );

    mux_rr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk(clk), .rst(rst), .push(push2), .pop(pop2), .din(bus.in2),
        .head(head2), .count(count2), .full(full2), .empty(empty2)
    );

    // On a tie the channel that did not win last time is served.
    always_comb begin
        loadable = (state == IDLE) || bus.out_ready;
        pick     = (!empty1 && !empty2) ? ~last : !empty2;
        load     = loadable && (!empty1 || !empty2);
        pop1     = load && (pick == SRC_IN1);
        pop2     = load && (pick == SRC_IN2);
        head_sel = (pick == SRC_IN2) ? head2 : head1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out_q <= '0;
            sel_q <= SRC_IN1;
            last  <= SRC_IN2;
        end else if (load) begin
            state <= hold_state(pick);
            out_q <= head_sel;
            sel_q <= pick;
            last  <= pick;
        end else if (loadable) begin
            state <= IDLE;
        end
    end

    assign bus.in1_ready = (count1 < CW'(DEPTH)) && !rst;
    assign bus.in2_ready = (count2 < CW'(DEPTH)) && !rst;
    assign bus.out       = out_q;
    assign bus.out_valid = (state != IDLE);
    assign bus.out_sel   = sel_q;

endmodule

// File: doc/mux_rr_feeder.md
MUX_RR_FEEDER -- requirements
Module: mux_rr_feeder

Interface
REQ-001 Parameter WIDTH, default 8, data width of every data port.
REQ-002 Parameter DEPTH, default 2, entries per input FIFO; legal values 2 or 4.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 IN1  input  WIDTH  channel-1 data word.
REQ-006 IN1_VALID  input  1  channel-1 word present.
REQ-007 IN1_READY  output  1  channel-1 FIFO can accept.
REQ-008 IN2  input  WIDTH  channel-2 data word.
REQ-009 IN2_VALID  input  1  channel-2 word present.
REQ-010 IN2_READY  output  1  channel-2 FIFO can accept.
REQ-011 OUT  output  WIDTH  registered selected word.
REQ-012 OUT_VALID  output  1  OUT holds an unconsumed word.
REQ-013 OUT_READY  input  1  downstream accepts OUT this cycle.
REQ-014 OUT_SEL  output  1  source of OUT: 0 = channel 1, 1 = channel 2 (same polarity as the 2:1 mux SEL).

Function
REQ-015 Channel n push occurs on an edge where INn_VALID and INn_READY are both high; pop occurs when the arbiter loads that channel's head word.
REQ-016 INn_READY shall equal (FIFO count < DEPTH) and not RST; no combinational path from OUT_READY or INn_VALID.
REQ-017 A simultaneous push and pop on one FIFO shall leave count unchanged and preserve FIFO order; pointers wrap modulo DEPTH.
REQ-018 Output register is loadable when OUT_VALID is low or OUT_READY is high.
REQ-019 When loadable: if exactly one FIFO is non-empty, load its head; if both are non-empty, load the channel other than LAST; if neither, OUT_VALID goes low, and OUT and OUT_SEL hold.
REQ-020 On each load, OUT <= head word, OUT_SEL <= chosen channel, OUT_VALID <= 1, LAST <= chosen channel.
REQ-021 When not loadable, OUT, OUT_SEL, OUT_VALID and LAST shall hold.
REQ-022 FSM states: IDLE (OUT_VALID=0), HOLD1 (word from ch1), HOLD2 (word from ch2); the next state is given by REQ-019/020; the state encodes OUT_VALID and OUT_SEL.
REQ-023 Latency: a word pushed at edge N into an empty FIFO, with IDLE and no competitor, appears with OUT_VALID high after edge N+1.
REQ-024 Throughput: with OUT_READY held high and both FIFOs non-empty, one word per cycle, strictly alternating channels.
REQ-025 A word is never dropped or duplicated; per-channel order is preserved.

Reset
REQ-026 While RST is high at an edge: FIFO counts and pointers = 0, state = IDLE, OUT = 0, OUT_VALID = 0, OUT_SEL = 0, LAST = 1 (channel 1 wins the first tie).
REQ-027 Reset asserted mid-operation discards all buffered and held words; the first cycle after release behaves as after power-up.
REQ-028 FIFO storage contents need not be reset.

Structure
REQ-029 Shared package mux_rr_pkg holds the WIDTH/DEPTH defaults, the state encoding (IDLE/HOLD1/HOLD2) and the source encodings SRC_IN1=0, SRC_IN2=1.
REQ-030 One sub-module mux_rr_fifo (WIDTH, DEPTH; push, pop, head, count, full, empty) is instantiated twice; the arbiter and output register live in the top module.

Verification
REQ-031 Single word: IN1=8'h01 valid one cycle, OUT_READY=1 -> OUT=8'h01, OUT_SEL=0, OUT_VALID high for exactly one cycle, after edge N+1.
REQ-032 Tie/fairness: both FIFOs preloaded with 8'h11,8'h12 / 8'h21,8'h22, then OUT_READY=1 -> OUT sequence 11,21,12,22 with OUT_SEL 0,1,0,1.
REQ-033 Backpressure: OUT_READY=0, push 3 words on IN2 with DEPTH=2 -> first word held on OUT, IN2_READY low after 3rd accept; release -> all 3 words delivered in order.
REQ-034 Full with simultaneous push/pop: FIFO full, OUT_READY=1, IN1_VALID=1 -> IN1_READY stays low that cycle (no bypass), count drops, next push accepted, no loss.
REQ-035 Reset mid-stream: RST pulsed with words buffered and OUT_VALID=1 -> next cycle all outputs at reset values, READYs high after release, old words never appear.
